// File: rtl/ascii_bit_streamer_pkg.sv
// rtl/ascii_bit_streamer_pkg.sv - shared state encoding and ASCII constants
package ascii_bit_streamer_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND_BIT = 3'd1;
    localparam logic [2:0] ST_SEND_CR  = 3'd2;
    localparam logic [2:0] ST_SEND_LF  = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_SEND_BIT = ST_SEND_BIT,
        S_SEND_CR  = ST_SEND_CR,
        S_SEND_LF  = ST_SEND_LF,
        S_FINISH   = ST_FINISH
    } state_t;

    localparam logic [6:0] CH_ZERO = 7'd48;
    localparam logic [6:0] CH_ONE  = 7'd49;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

endpackage

// File: rtl/ascii_bit_streamer_if.sv
// rtl/ascii_bit_streamer_if.sv - command and character stream bundle for the bit streamer
interface ascii_bit_streamer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [7:0]       char_out;
    logic             char_valid;
    logic             char_ready;
    logic             busy;
    logic             done;

    modport master (
        output start, data_in, char_ready,
        input  char_out, char_valid, busy, done
    );

    modport slave (
        input  start, data_in, char_ready,
        output char_out, char_valid, busy, done
    );
endinterface

// File: rtl/ascii_bit_streamer_binary_to_ascii.sv
// rtl/ascii_bit_streamer_binary_to_ascii.sv - ASCII '0'/'1' of one word bit, column 0 = MSB
module ascii_bit_streamer_binary_to_ascii
    import ascii_bit_streamer_pkg::*;
#(
    parameter int size = 32
) (
    input  logic [size-1:0]      in,
    input  logic [$clog2(size):0] col,
    output logic [6:0]           out
);
    localparam logic [size-1:0] MSB_MASK = {1'b1, {(size-1){1'b0}}};

    logic sel_bit;

    // Sliding a one-hot mask down from the MSB selects in[size-1-col] without a subtraction.
    assign sel_bit = |(in & (MSB_MASK >> col));
    assign out     = sel_bit ? CH_ONE : CH_ZERO;
endmodule

// File: rtl/ascii_bit_streamer.sv
// rtl/ascii_bit_streamer.sv - streams a word as ASCII bits, MSB first, with optional CR LF
module ascii_bit_streamer
    import ascii_bit_streamer_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit SEP_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    ascii_bit_streamer_if.slave bus
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  COL_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [6:0]       bit_char;

    ascii_bit_streamer_binary_to_ascii #(.size(WIDTH)) u_binary_to_ascii (
        .in  (shadow_q),
        .col ({1'b0, col_q}),
        .out (bit_char)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        shadow_d       = shadow_q;
        bus.char_out   = 8'h00;
        bus.char_valid = 1'b0;
        bus.busy       = (state_q != S_IDLE);
        bus.done       = (state_q == S_FINISH);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    shadow_d = bus.data_in;
                    col_d    = '0;
                    state_d  = S_SEND_BIT;
                end
            end
            S_SEND_BIT: begin
                bus.char_valid = 1'b1;
                bus.char_out   = {1'b0, bit_char};
                if (bus.char_ready) begin
                    if (col_q == COL_LAST) begin
                        state_d = SEP_EN ? S_SEND_CR : S_FINISH;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_SEND_CR: begin
                bus.char_valid = 1'b1;
                bus.char_out   = CH_CR;
                if (bus.char_ready) state_d = S_SEND_LF;
            end
            S_SEND_LF: begin
                bus.char_valid = 1'b1;
                bus.char_out   = CH_LF;
                if (bus.char_ready) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ascii_bit_streamer.sv
// tb/tb_ascii_bit_streamer.sv - randomized self-checking bench against a character-list model
module tb_ascii_bit_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rdy = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] din = '0;

    logic [7:0]  co;
    logic        cv, bz, dn;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ascii_bit_streamer_if #(.WIDTH(4)) ifa ();
    ascii_bit_streamer_if #(.WIDTH(8)) ifb ();

    assign ifa.start      = start && !sel;
    assign ifa.data_in    = din[3:0];
    assign ifa.char_ready = rdy;
    assign ifb.start      = start && sel;
    assign ifb.data_in    = din[7:0];
    assign ifb.char_ready = rdy;

    assign co = sel ? ifb.char_out   : ifa.char_out;
    assign cv = sel ? ifb.char_valid : ifa.char_valid;
    assign bz = sel ? ifb.busy       : ifa.busy;
    assign dn = sel ? ifb.done       : ifa.done;

    ascii_bit_streamer #(.WIDTH(4), .SEP_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    ascii_bit_streamer #(.WIDTH(8), .SEP_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_word(input bit which, input logic [31:0] word, input int stall_pct,
                            input int stall_idx, input int stall_len, input bit midstart,
                            input bit check_tput);
        int         width = which ? 8 : 4;
        bit         sep = !which;
        int         exp_len;
        int         n_xfer = 0;
        int         cyc = 0;
        int         left = stall_len;
        bit         got_done = 1'b0;
        bit         was_stalled = 1'b0;
        logic [7:0] held = 8'h00;

        exp_q.delete();
        for (int i = width - 1; i >= 0; i--)
            exp_q.push_back(((word >> i) & 32'd1) != 0 ? 8'h31 : 8'h30);
        if (sep) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        exp_len = exp_q.size();

        sel   = which;
        din   = word;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din   = $urandom;

        while (!got_done && cyc < 200) begin
            if (n_xfer == stall_idx && left > 0) begin
                rdy = 1'b0;
                left--;
            end else begin
                rdy = ($urandom_range(99) >= stall_pct);
            end
            if (midstart && cyc == 2) begin
                start = 1'b1;
                din   = '1;
            end
            @(negedge clk);
            if (cyc == 0) begin
                check_eq("first_valid", cv, 1);
                check_eq("busy_after_start", bz, 1);
            end
            if (was_stalled) begin
                check_eq("hold_valid", cv, 1);
                check_eq("hold_char", co, held);
            end
            if (cv && rdy) begin
                if (exp_q.size() == 0) check_eq("extra_char", n_xfer + 1, exp_len);
                else                   check_eq("char", co, exp_q.pop_front());
                n_xfer++;
            end
            was_stalled = cv && !rdy;
            held        = co;
            if (dn) begin
                got_done = 1'b1;
                check_eq("xfers_at_done", n_xfer, exp_len);
                check_eq("done_valid_low", cv, 0);
                if (check_tput) check_eq("throughput", cyc, exp_len);
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check_eq("done_seen", got_done, 1);
        @(negedge clk);
        check_eq("busy_after_done", bz, 0);
        check_eq("done_one_cycle", dn, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #3;
        check_eq("rst_a_char", ifa.char_out, 8'h00);
        check_eq("rst_a_valid", ifa.char_valid, 0);
        check_eq("rst_a_busy", ifa.busy, 0);
        check_eq("rst_a_done", ifa.done, 0);
        check_eq("rst_b_valid", ifb.char_valid, 0);
        check_eq("rst_b_busy", ifb.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_word(1'b0, 32'hA, 0, -1, 0, 1'b0, 1'b1);
        run_word(1'b0, 32'hA, 0, 1, 3, 1'b0, 1'b0);
        run_word(1'b0, 32'hA, 0, -1, 0, 1'b1, 1'b1);

        // abort while the third bit (col 2) is on the bus
        sel   = 1'b0;
        din   = 32'hA;
        rdy   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_rst_char", co, 8'h31);
        #3;
        rst = 1'b1;
        #1;
        check_eq("abort_valid", cv, 0);
        check_eq("abort_busy", bz, 0);
        check_eq("abort_done", dn, 0);
        check_eq("abort_char", co, 8'h00);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        run_word(1'b0, 32'h1, 0, -1, 0, 1'b0, 1'b1);

        run_word(1'b1, 32'hA5, 0, -1, 0, 1'b0, 1'b1);

        for (int k = 0; k < 40; k++) begin
            bit          w = 1'($urandom_range(1));
            logic [31:0] word = $urandom & (w ? 32'hFF : 32'hF);
            run_word(w, word, $urandom_range(60), $urandom_range(7), $urandom_range(3),
                     1'($urandom_range(1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
